// File: rtl/gain_ramp_ctrl.sv
// Gain coefficient sequencer: ramps toward a target one step per RATE+1 sample ticks.
// Optional mute ramp-down/restore is compiled in with GAIN_RAMP_MUTE_EN.
module gain_ramp_ctrl #(
  parameter int COEFW     = 18,
  parameter int STEPW     = 12,
  parameter int RATEW     = 8,
  parameter int GAIN_INIT = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COEFW-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [STEPW-1:0] step,
  input  logic [RATEW-1:0] rate,
  input  logic             sample_tick,
`ifdef GAIN_RAMP_MUTE_EN
  input  logic             mute,
`endif
  output logic [COEFW-1:0] gain,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RAMP, MUTE_DN, MUTED} state_t;

  state_t           state_q, state_d;
  logic [COEFW-1:0] gain_q, gain_d;
  logic [COEFW-1:0] tgt_q, tgt_d;
  logic [STEPW-1:0] step_q, step_d;
  logic [RATEW-1:0] rate_q, rate_d;
  logic [RATEW-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef GAIN_RAMP_MUTE_EN
  logic [COEFW-1:0] saved_q, saved_d;
  logic             mute_q;
  logic             in_mute;
  logic [COEFW-1:0] dest;
`endif

  // Distance to target is one bit wider so full-scale swings cannot wrap.
  logic [COEFW:0]       diff, mag;
  logic [COEFW+STEPW:0] mag_w, step_w;
  logic                 arrive;
  logic [COEFW-1:0]     stepped, tick_gain;
  logic [RATEW-1:0]     tick_cnt;
  logic                 tick_end;

  always_comb begin
    diff      = {tgt_q[COEFW-1], tgt_q} - {gain_q[COEFW-1], gain_q};
    mag       = diff[COEFW] ? -diff : diff;
    mag_w     = {{STEPW{1'b0}}, mag};
    step_w    = {{(COEFW+1){1'b0}}, step_q};
    arrive    = (step_q == '0) || (mag_w <= step_w);
    stepped   = diff[COEFW] ? gain_q - COEFW'(step_q) : gain_q + COEFW'(step_q);
    tick_gain = (cnt_q == '0) ? (arrive ? tgt_q : stepped) : gain_q;
    tick_cnt  = (cnt_q == '0) ? rate_q : cnt_q - 1'b1;
    tick_end  = (cnt_q == '0) && arrive;
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    rate_d  = rate_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef GAIN_RAMP_MUTE_EN
    saved_d = saved_q;
    in_mute = (state_q == MUTE_DN) || (state_q == MUTED);
    dest    = target_valid ? target : saved_q;
    if (mute && !mute_q && !in_mute) begin
      // Ramp destination becomes 0; the real target is parked in saved.
      saved_d = target_valid ? target : tgt_q;
      tgt_d   = '0;
      cnt_d   = rate_q;
      state_d = (gain_q == '0) ? MUTED : MUTE_DN;
    end else if (!mute && mute_q && in_mute) begin
      tgt_d = dest;
      cnt_d = rate_q;
      if (dest == gain_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (in_mute) begin
      if (target_valid) saved_d = target;
      if (state_q == MUTE_DN && sample_tick) begin
        gain_d = tick_gain;
        cnt_d  = tick_cnt;
        if (tick_end) state_d = MUTED;
      end
    end else
`endif
    if (target_valid) begin
      // Accept wins over a coincident tick; the counter restarts from the new rate.
      tgt_d  = target;
      step_d = step;
      rate_d = rate;
      cnt_d  = rate;
      if (target == gain_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (state_q == RAMP && sample_tick) begin
      gain_d = tick_gain;
      cnt_d  = tick_cnt;
      if (tick_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
    busy_d = (state_d == RAMP) || (state_d == MUTE_DN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gain_q  <= COEFW'(GAIN_INIT);
      tgt_q   <= COEFW'(GAIN_INIT);
      step_q  <= '0;
      rate_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GAIN_RAMP_MUTE_EN
      saved_q <= COEFW'(GAIN_INIT);
      mute_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef GAIN_RAMP_MUTE_EN
      saved_q <= saved_d;
      mute_q  <= mute;
`endif
    end
  end

  assign target_ready = 1'b1;
  assign gain         = gain_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed bench for gain_ramp_ctrl: table of per-cycle vectors plus hand sequences.
// Mute sequence is exercised only when GAIN_RAMP_MUTE_EN is defined.
module tb_gain_ramp_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] target;
  logic               target_valid;
  logic               target_ready;
  logic [15:0]        step;
  logic [7:0]         rate;
  logic               sample_tick;
  logic signed [17:0] gain;
  logic               busy;
  logic               done;
`ifdef GAIN_RAMP_MUTE_EN
  logic               mute = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  gain_ramp_ctrl #(.COEFW(18), .STEPW(16), .RATEW(8), .GAIN_INIT(65536)) dut (
    .clk(clk), .rst(rst), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .step(step), .rate(rate), .sample_tick(sample_tick),
`ifdef GAIN_RAMP_MUTE_EN
    .mute(mute),
`endif
    .gain(gain), .busy(busy), .done(done)
  );

  typedef struct {
    logic               acc;
    logic signed [17:0] tgt;
    logic [15:0]        stp;
    logic [7:0]         rt;
    logic               tick;
    logic signed [17:0] eg;
    logic               eb;
    logic               ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic acc, input int tgt, input int stp, input int rt,
                     input logic tick, input int eg, input logic eb, input logic ed);
    vec_t v;
    v.acc = acc; v.tgt = 18'(tgt); v.stp = 16'(stp); v.rt = 8'(rt);
    v.tick = tick; v.eg = 18'(eg); v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic acc, input int tgt, input int stp, input int rt,
                       input logic tick);
    target_valid = acc;
    target       = 18'(tgt);
    step         = 16'(stp);
    rate         = 8'(rt);
    sample_tick  = tick;
  endtask

  task automatic chk3(input string tag, input int eg, input logic eb, input logic ed);
    chk({tag, " gain"}, gain, eg);
    chk({tag, " busy"}, busy, eb);
    chk({tag, " done"}, done, ed);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    cyc();
    chk3("reset", 65536, 0, 0);
    chk("reset ready", target_ready, 1);
    rst = 1'b0;

    // 65536 -> 0, step 16384, rate 0
    add(1, 0, 16384, 0, 0, 65536, 1, 0);
    add(0, 0, 0, 0, 1, 49152, 1, 0);
    add(0, 0, 0, 0, 1, 32768, 1, 0);
    add(0, 0, 0, 0, 1, 16384, 1, 0);
    add(0, 0, 0, 0, 1, 0,     0, 1);
    add(0, 0, 0, 0, 1, 0,     0, 0);
    // 0 -> 1000, step 300, rate 2, last step clamped
    add(1, 1000, 300, 2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,    1, 0);
    add(0, 0, 0, 0, 0, 0,    1, 0);
    add(0, 0, 0, 0, 1, 0,    1, 0);
    add(0, 0, 0, 0, 1, 300,  1, 0);
    add(0, 0, 0, 0, 1, 300,  1, 0);
    add(0, 0, 0, 0, 1, 300,  1, 0);
    add(0, 0, 0, 0, 1, 600,  1, 0);
    add(0, 0, 0, 0, 1, 600,  1, 0);
    add(0, 0, 0, 0, 1, 600,  1, 0);
    add(0, 0, 0, 0, 1, 900,  1, 0);
    add(0, 0, 0, 0, 1, 900,  1, 0);
    add(0, 0, 0, 0, 1, 900,  1, 0);
    add(0, 0, 0, 0, 1, 1000, 0, 1);
    add(0, 0, 0, 0, 0, 1000, 0, 0);
    // target equal to gain, twice back-to-back
    add(1, 1000, 5, 0, 0, 1000, 0, 1);
    add(1, 1000, 5, 0, 1, 1000, 0, 1);
    add(0, 0, 0, 0, 0, 1000, 0, 0);
    // step 0 jumps on the first qualifying tick
    add(1, -5000, 0, 3, 0, 1000, 1, 0);
    add(0, 0, 0, 0, 1, 1000,  1, 0);
    add(0, 0, 0, 0, 1, 1000,  1, 0);
    add(0, 0, 0, 0, 1, 1000,  1, 0);
    add(0, 0, 0, 0, 1, -5000, 0, 1);
    // full-scale swing 131071 -> -131072
    add(1, 131071, 0, 0, 0, -5000, 1, 0);
    add(0, 0, 0, 0, 1, 131071, 0, 1);
    add(1, -131072, 65535, 0, 0, 131071, 1, 0);
    add(0, 0, 0, 0, 1, 65536,   1, 0);
    add(0, 0, 0, 0, 1, 1,       1, 0);
    add(0, 0, 0, 0, 1, -65534,  1, 0);
    add(0, 0, 0, 0, 1, -131069, 1, 0);
    add(0, 0, 0, 0, 1, -131072, 0, 1);
    add(0, 0, 0, 0, 1, -131072, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].acc, int'(vecs[i].tgt), int'(vecs[i].stp), int'(vecs[i].rt), vecs[i].tick);
      cyc();
      chk3($sformatf("vec%0d", i), int'(vecs[i].eg), vecs[i].eb, vecs[i].ed);
    end

    // Retarget at 32768 with a coincident tick: tick dropped, ramp reverses.
    rst = 1'b1; drive(0, 0, 0, 0, 0); cyc(); rst = 1'b0;
    drive(1, 0, 16384, 0, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc(); cyc();
    chk3("rev pre", 32768, 1, 0);
    drive(1, 65536, 16384, 0, 1); cyc();
    chk3("rev accept", 32768, 1, 0);
    drive(0, 0, 0, 0, 1); cyc();
    chk3("rev up1", 49152, 1, 0);
    cyc();
    chk3("rev up2", 65536, 0, 1);

    // Reset mid-ramp aborts and restores the initial gain.
    drive(1, 0, 1000, 0, 0); cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk3("midrst pre", 64536, 1, 0);
    rst = 1'b1; cyc(); rst = 1'b0; drive(0, 0, 0, 0, 0);
    chk3("midrst", 65536, 0, 0);

`ifdef GAIN_RAMP_MUTE_EN
    drive(1, 65536, 32768, 0, 0); cyc();
    chk3("mute eq", 65536, 0, 1);
    drive(0, 0, 0, 0, 0); mute = 1'b1; cyc();
    chk3("mute start", 65536, 1, 0);
    drive(0, 0, 0, 0, 1); cyc();
    chk3("mute dn1", 32768, 1, 0);
    cyc();
    chk3("mute dn2", 0, 0, 0);
    cyc();
    chk3("mute hold", 0, 0, 0);
    drive(1, 16384, 32768, 0, 1); cyc();
    chk3("mute tgt", 0, 0, 0);
    drive(0, 0, 0, 0, 0); mute = 1'b0; cyc();
    chk3("unmute", 0, 1, 0);
    drive(0, 0, 0, 0, 1); cyc();
    chk3("unmute arr", 16384, 0, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    drive(1, 65536, 32768, 0, 0); cyc();
    drive(0, 0, 0, 0, 0); mute = 1'b1; cyc();
    drive(0, 0, 0, 0, 1); cyc();
    chk3("mrst pre", 32768, 1, 0);
    mute = 1'b0; rst = 1'b1; cyc(); rst = 1'b0; drive(0, 0, 0, 0, 0);
    chk3("mrst", 65536, 0, 0);
    cyc();
    chk3("mrst idle", 65536, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
